// File: rtl/mux_pkg.sv
// Shared definitions for the 8:1 round-robin output multiplexer.
// Holds the lane count, the lane index type, the output register state
// encoding and the modulo-8 lane increment used by the rotating pointer.
package mux_pkg;

    localparam int N_LANES = 8;

    typedef logic [2:0] lane_idx_t;

    // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Next lane after l, wrapping 7 -> 0 through natural 3-bit overflow
    function automatic lane_idx_t next_lane(input lane_idx_t l);
        return l + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Rotating-priority search over 8 request lanes.
// The search starts at i_rr_ptr and walks upward modulo 8; the first lane
// with a request wins. Purely combinational: the caller owns the pointer.
module rr_arbiter_8
    import mux_pkg::*;
(
    input  logic [N_LANES-1:0] i_in_valid,
    input  lane_idx_t          i_rr_ptr,
    output logic [N_LANES-1:0] o_grant,
    output lane_idx_t          o_grant_idx,
    output logic               o_any_valid
);

    // Walk lanes rr_ptr, rr_ptr+1, ... and latch the first requester found
    always_comb begin
        lane_idx_t w_lane;
        o_any_valid = 1'b0;
        o_grant_idx = '0;
        w_lane      = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_lane = i_rr_ptr + lane_idx_t'(k);
            if (!o_any_valid && i_in_valid[w_lane]) begin
                o_any_valid = 1'b1;
                o_grant_idx = w_lane;
            end
        end
        o_grant = o_any_valid
                ? ({{(N_LANES-1){1'b0}}, 1'b1} << o_grant_idx)
                : '0;
    end

endmodule

// File: rtl/mux_8x1_rr.sv
// 8:1 round-robin multiplexer with a one-word registered output stage.
// Each lane offers a word with in_valid/in_ready; the granted lane's word is
// captured into the output register together with its lane index (out_sel).
// Optional build macro MUX_8X1_RR_GRANT_CNT_EN adds grant_cnt, a saturating
// count of completed output handshakes.
//
// Handshake rule for every port: a word moves only on a rising clk edge at
// which that port's valid and ready are both high. in_ready is combinational,
// one-hot or zero, and high only for the granted lane when the output
// register can accept a word (EMPTY, or FULL and being drained this cycle).
module mux_8x1_rr
    import mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_LANES-1:0]              in_valid,
    input  logic [N_LANES-1:0][DATA_W-1:0]  in_data,
    output logic [N_LANES-1:0]              in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [2:0]                      out_sel
`ifdef MUX_8X1_RR_GRANT_CNT_EN
    ,
    output logic [15:0]                     grant_cnt
`endif
);

    out_state_t          r_state;
    out_state_t          w_next_state;
    logic [DATA_W-1:0]   r_out_data;
    lane_idx_t           r_out_sel;
    lane_idx_t           r_rr_ptr;

    logic [N_LANES-1:0]  w_grant;
    lane_idx_t           w_grant_idx;
    logic                w_any_valid;
    logic                w_load;
    logic                w_take;
    logic                w_out_hs;

    rr_arbiter_8 u_arb (
        .i_in_valid  (in_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_valid (w_any_valid)
    );

    // Load window and handshakes; in_ready is forced low while reset is held
    always_comb begin
        w_load   = (r_state == ST_EMPTY) || out_ready;
        w_take   = w_load && w_any_valid;
        w_out_hs = (r_state == ST_FULL) && out_ready;
        in_ready = (w_take && rst_n) ? w_grant : '0;
    end

    // Next-state logic for the output register occupancy
    always_comb begin
        w_next_state = r_state;
        if (w_take) begin
            w_next_state = ST_FULL;
        end else if (w_out_hs) begin
            w_next_state = ST_EMPTY;
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the granted word and advance the pointer past the winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_sel  <= '0;
            r_rr_ptr   <= '0;
        end else if (w_take) begin
            r_out_data <= in_data[w_grant_idx];
            r_out_sel  <= w_grant_idx;
            r_rr_ptr   <= next_lane(w_grant_idx);
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

`ifdef MUX_8X1_RR_GRANT_CNT_EN
    logic [15:0] r_grant_cnt;

    // Count completed output handshakes, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else if (w_out_hs && (r_grant_cnt != 16'hFFFF)) begin
            r_grant_cnt <= r_grant_cnt + 16'd1;
        end
    end

    assign grant_cnt = r_grant_cnt;
`else
    // No handshake counter in this build
`endif

endmodule

// File: tb/tb_mux_8x1_rr.sv
// Self-checking bench for mux_8x1_rr: directed scenarios followed by
// randomized traffic, compared against a lane-search model and a queue
// holding the word expected in the output register.
module tb_mux_8x1_rr;

  localparam int DW = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             in_valid = '0;
  logic [7:0][DW-1:0]     in_data = '0;
  logic [7:0]             in_ready;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DW-1:0]          out_data;
  logic [2:0]             out_sel;
`ifdef MUX_8X1_RR_GRANT_CNT_EN
  logic [15:0]            grant_cnt;
`endif

  mux_8x1_rr #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef MUX_8X1_RR_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // scoreboard: {sel, data} of the word expected in the output register
  logic [10:0] exp_q[$];
  int m_ptr = 0;
  int m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected in_ready from the arbitration rule
  function automatic logic [7:0] model_ready();
    logic [7:0] r;
    int lane;
    r = '0;
    if (exp_q.size() != 0 && !out_ready) return r;
    for (int k = 0; k < 8; k++) begin
      lane = (m_ptr + k) % 8;
      if (in_valid[lane]) begin
        r = 8'd1 << lane;
        return r;
      end
    end
    return r;
  endfunction

  // One clock: check at negedge, advance the model at posedge, return at posedge+1
  task automatic tick();
    logic [7:0] exp_rdy;
    logic drain;
    int lane;
    @(negedge clk);
    exp_rdy = model_ready();
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("out_data", {24'd0, out_data}, {24'd0, exp_q[0][7:0]});
      check("out_sel", {29'd0, out_sel}, {29'd0, exp_q[0][10:8]});
    end
    check("in_ready", {24'd0, in_ready}, {24'd0, exp_rdy});
    check("in_ready_onehot0", {31'd0, $onehot0(in_ready)}, 32'd1);
`ifdef MUX_8X1_RR_GRANT_CNT_EN
    check("grant_cnt", {16'd0, grant_cnt}, m_cnt);
`endif
    drain = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (drain) begin
      void'(exp_q.pop_front());
      if (m_cnt < 65535) m_cnt++;
    end
    if (exp_rdy != 0) begin
      lane = 0;
      for (int k = 0; k < 8; k++) if (exp_rdy[k]) lane = k;
      exp_q.push_back({3'(lane), in_data[lane]});
      m_ptr = (lane + 1) % 8;
    end
    #1;
  endtask

  // driver: asynchronous reset with immediate output checks
  task automatic do_reset();
    in_valid = 8'hFF;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {24'd0, in_ready}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_sel", {29'd0, out_sel}, 32'd0);
    exp_q.delete();
    m_ptr = 0;
    m_cnt = 0;
`ifdef MUX_8X1_RR_GRANT_CNT_EN
    check("rst_grant_cnt", {16'd0, grant_cnt}, 32'd0);
`endif
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver: random lane data
  task automatic rand_data();
    for (int i = 0; i < 8; i++) in_data[i] = DW'($urandom);
  endtask

  initial begin
    // reset at time zero
    do_reset();

    // single word from lane 0
    in_valid = 8'h01;
    in_data[0] = 8'hA5;
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    tick();
    tick();

    // all lanes valid: sel 0..7,0,1 one per cycle
    do_reset();
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      tick();
    end

    // FULL with back-pressure: frozen output, no in_ready, then lane 4 loads
    in_valid = 8'h01;
    rand_data();
    tick();
    out_ready = 1'b0;
    in_valid = 8'h10;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    tick();
    tick();

    // pointer at 7: lane 7 then lane 0
    in_valid = 8'h40;
    rand_data();
    tick();
    in_valid = 8'h81;
    tick();
    tick();
    in_valid = '0;
    tick();
    tick();

    // reset while FULL, then search restarts at lane 0
    in_valid = 8'hFF;
    rand_data();
    tick();
    tick();
    check("full_before_rst", {31'd0, out_valid}, 32'd1);
    do_reset();
    in_valid = 8'h0C;
    rand_data();
    tick();
    in_valid = '0;
    tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: in_valid = '0;
        1: in_valid = 8'd1 << $urandom_range(0, 7);
        default: in_valid = 8'($urandom);
      endcase
      rand_data();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

`ifdef MUX_8X1_RR_GRANT_CNT_EN
    // ten handshakes, then saturation from a value near the top
    do_reset();
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      rand_data();
      tick();
    end
    check("grant_cnt_10", {16'd0, grant_cnt}, 32'd10);
    force dut.r_grant_cnt = 16'hFFFD;
    #1;
    release dut.r_grant_cnt;
    m_cnt = 65533;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      tick();
    end
    check("grant_cnt_sat", {16'd0, grant_cnt}, 32'h0000FFFF);
`endif

    // drain
    in_valid = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_8x1_rr.md
MUX_8X1_RR -- requirements
Module: mux_8x1_rr

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the lane and output data width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 in_valid  input  8  SHALL flag, per lane i, that in_data[i] holds a word to send.
REQ-005 in_data  input  8 x DATA_W  SHALL carry one data word per lane.
REQ-006 in_ready  output  8  SHALL flag, per lane i, that lane i's word is taken this cycle.
REQ-007 out_valid  output  1  SHALL flag that out_data and out_sel hold a word.
REQ-008 out_ready  input  1  SHALL flag that the downstream consumer takes the word this cycle.
REQ-009 out_data  output  DATA_W  SHALL carry the forwarded word.
REQ-010 out_sel  output  3  SHALL carry the source lane index of out_data (the demux sel of the far end).

Function
REQ-011 A transfer on any port SHALL occur only in a cycle where its valid and ready are both high at the rising edge.
REQ-012 The block SHALL keep a one-word output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 The block SHALL keep a 3-bit round-robin pointer rr_ptr.
REQ-014 Grant SHALL go to the first lane with in_valid=1, searching rr_ptr, rr_ptr+1, ... modulo 8; the search SHALL wrap 7->0.
REQ-015 The load condition SHALL be: state EMPTY, or state FULL with out_ready=1.
REQ-016 in_ready SHALL be one-hot or zero; it SHALL be combinational; only the granted lane SHALL see in_ready high, and only when the load condition holds.
REQ-017 On a load, the register SHALL capture out_data<=in_data[g] and out_sel<=g, set out_valid<=1, and set rr_ptr<=(g+1) mod 8.
REQ-018 In FULL, out_data and out_sel SHALL stay stable until out_ready=1.
REQ-019 Transitions:
- EMPTY->FULL on a load.
- FULL->EMPTY on out_ready=1 with no in_valid.
- FULL->FULL on out_ready=1 with a load (drain and load in the same cycle).
- FULL->FULL holding on out_ready=0.
REQ-020 Latency SHALL be 1 cycle from input handshake to out_valid.
REQ-021 Sustained throughput SHALL be 1 word per cycle.
REQ-022 With no in_valid, rr_ptr SHALL stay unchanged.
REQ-023 A lane held valid SHALL wait at most 7 grants to other lanes before its own grant (starvation-free).
REQ-024 in_valid going high while out_ready=0 and FULL SHALL produce no in_ready, and no word SHALL be lost.

Reset
REQ-025 On rst_n=0, out_valid SHALL be 0, out_data 0, out_sel 0, rr_ptr 0, and in_ready all 0, immediately and without waiting for clk.
REQ-026 A reset asserted while FULL SHALL discard the held word; the first grant after release SHALL start search at lane 0.

Configuration
REQ-027 Macro MUX_8X1_RR_GRANT_CNT_EN SHALL, when defined, add port grant_cnt  output  16.
- grant_cnt SHALL be a count of completed output handshakes that saturates at 16'hFFFF.
- grant_cnt SHALL be cleared by reset.
REQ-028 Without MUX_8X1_RR_GRANT_CNT_EN, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-029 A shared package mux_pkg SHALL hold:
- the constant N_LANES=8;
- the typedef lane_idx_t (logic [2:0]);
- the function next_lane (modulo-8 increment).
REQ-030 The sub-module rr_arbiter_8 SHALL implement the rotating priority search (inputs in_valid and rr_ptr; outputs a one-hot grant and its index); mux_8x1_rr SHALL instantiate it once.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset then in_valid=8'h01, data0=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_sel=0.
- in_valid=8'hFF held, out_ready=1 -> out_sel sequence 0,1,2,...,7,0, one word per cycle, in_ready one-hot each cycle.
- FULL with out_ready=0 for 5 cycles and in_valid=8'h10 -> out_data/out_sel frozen and in_ready=0; out_ready=1 -> lane 4 loaded the following cycle.
- rr_ptr=7 state, in_valid=8'h81 -> lane 7 granted first, then lane 0 (wrap).
- rst_n=0 mid-stream while FULL -> out_valid=0 at once; after release, in_valid=8'h0C -> out_sel=2 first.
- MUX_8X1_RR_GRANT_CNT_EN defined, 10 handshakes -> grant_cnt=10; counter pre-forced near 16'hFFFF -> holds 16'hFFFF.
